// File: rtl/wash_phase_timer.sv
// Phase-aware duration timer for the washing-machine controller: decodes the active phase from
// actuator outputs and raises a done flag after a load-scaled time. Optional door pause: DOOR_PAUSE_EN.
module wash_phase_timer #(
  parameter int TICK_DIV = 50_000_000,
  parameter int CW       = 16,
  parameter int FILL_T   = 30,
  parameter int WASH_T   = 600,
  parameter int RINSE_T  = 300,
  parameter int DRAIN_T  = 60,
  parameter int SPIN_T   = 120
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic [1:0] load,
  input  logic       water,
  input  logic       agitator,
  input  logic       motor,
  input  logic       pump,
  input  logic       speed,
`ifdef DOOR_PAUSE_EN
  input  logic       door,
`endif
  output logic       td,
  output logic       tf,
  output logic       tr,
  output logic       ts,
  output logic       tw
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  // P_HOLD only ever appears on the decoded side; the phase register never holds it.
  typedef enum logic [2:0] {
    P_IDLE, P_FILL, P_WASH, P_RINSE, P_DRAIN, P_SPIN, P_HOLD
  } phase_t;

  phase_t          phase_q, phase_d, dec;
  logic [PW-1:0]   pre_q, pre_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [4:0]      flags_q, flags_d, phase_flag;  // {td, tf, tr, ts, tw}
  logic            agit_q, agit_d;
  logic [1:0]      load_q, load_d;
  logic [CW-1:0]   base, mult, target;
  logic [4:0]      act;
  logic            paused;

`ifdef DOOR_PAUSE_EN
  assign paused = door;
`else
  assign paused = 1'b0;
`endif

  assign act = {water, agitator, motor, pump, speed};

  always_comb begin
    dec = P_HOLD;
    casez (act)
      5'b10000: dec = P_FILL;
      5'b0111?: dec = agit_q ? P_RINSE : P_WASH;
      5'b00010: dec = P_DRAIN;
      5'b00111: dec = P_SPIN;
      5'b00000: dec = P_IDLE;
      default:  dec = P_HOLD;
    endcase
  end

  always_comb begin
    base       = '0;
    phase_flag = 5'b00000;
    case (phase_q)
      P_FILL:  begin base = CW'(FILL_T);  phase_flag = 5'b01000; end
      P_WASH:  begin base = CW'(WASH_T);  phase_flag = 5'b00001; end
      P_RINSE: begin base = CW'(RINSE_T); phase_flag = 5'b00100; end
      P_DRAIN: begin base = CW'(DRAIN_T); phase_flag = 5'b10000; end
      P_SPIN:  begin base = CW'(SPIN_T);  phase_flag = 5'b00010; end
      default: begin base = '0;           phase_flag = 5'b00000; end
    endcase
  end

  assign mult    = CW'(load_q) + CW'(1);
  assign target  = base * mult;
  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    phase_d = phase_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    flags_d = flags_q;
    agit_d  = agit_q;
    load_d  = load_q;
    if (clr) begin
      phase_d = P_IDLE;
      pre_d   = '0;
      cnt_d   = '0;
      flags_d = '0;
      agit_d  = 1'b0;
      load_d  = '0;
    end else if (!paused && dec != P_HOLD) begin
      if (dec != phase_q) begin
        phase_d = dec;
        pre_d   = '0;
        cnt_d   = '0;
        flags_d = '0;
        if (phase_q == P_WASH || phase_q == P_RINSE) agit_d = 1'b1;
        if (phase_q == P_IDLE && dec == P_FILL) load_d = load;
      end else if (phase_q != P_IDLE && cnt_q != target) begin
        // Once the unit count hits target both counters stop, so the flag simply holds.
        if (pre_q == PRE_LAST) begin
          pre_d = '0;
          cnt_d = cnt_inc;
          if (cnt_inc == target) flags_d = phase_flag;
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= P_IDLE;
      pre_q   <= '0;
      cnt_q   <= '0;
      flags_q <= '0;
      agit_q  <= 1'b0;
      load_q  <= '0;
    end else begin
      phase_q <= phase_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
      agit_q  <= agit_d;
      load_q  <= load_d;
    end
  end

  assign {td, tf, tr, ts, tw} = flags_q;

endmodule

// File: tb/tb_wash_phase_timer.sv
// Bench for wash_phase_timer: directed scenarios plus random actuator sequences, checked
// every edge against an elapsed-edge reference model.
module tb_wash_phase_timer;

  localparam int TICK_DIV = 4;
  localparam int CW       = 8;
  localparam int FILL_T   = 3;
  localparam int WASH_T   = 5;
  localparam int RINSE_T  = 2;
  localparam int DRAIN_T  = 2;
  localparam int SPIN_T   = 3;

  localparam logic [4:0] A_FILL  = 5'b10000;
  localparam logic [4:0] A_AGIT  = 5'b01110;
  localparam logic [4:0] A_AGIT1 = 5'b01111;
  localparam logic [4:0] A_DRAIN = 5'b00010;
  localparam logic [4:0] A_SPIN  = 5'b00111;
  localparam logic [4:0] A_IDLE  = 5'b00000;
  localparam logic [4:0] A_ILL   = 5'b11000;

  logic       clk = 1'b0;
  logic       reset_n, clr;
  logic [1:0] load;
  logic       water, agitator, motor, pump, speed;
  logic       door_v;
  logic       td, tf, tr, ts, tw;

  int checks   = 0;
  int failures = 0;

  // model state: phase code 0 idle,1 fill,2 wash,3 rinse,4 drain,5 spin
  int m_phase, m_elapsed, m_load, m_agit;

  always #5 clk = ~clk;

  wash_phase_timer #(
    .TICK_DIV(TICK_DIV), .CW(CW), .FILL_T(FILL_T), .WASH_T(WASH_T),
    .RINSE_T(RINSE_T), .DRAIN_T(DRAIN_T), .SPIN_T(SPIN_T)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clr(clr), .load(load),
    .water(water), .agitator(agitator), .motor(motor), .pump(pump), .speed(speed),
`ifdef DOOR_PAUSE_EN
    .door(door_v),
`endif
    .td(td), .tf(tf), .tr(tr), .ts(ts), .tw(tw)
  );

  task automatic check_eq(input string tag, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s flags{td,tf,tr,ts,tw} got=%b expected=%b at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int decode(input logic [4:0] a, input int agit);
    if (a == 5'b10000) return 1;
    if (a[4:1] == 4'b0111) return (agit != 0) ? 3 : 2;
    if (a == 5'b00010) return 4;
    if (a == 5'b00111) return 5;
    if (a == 5'b00000) return 0;
    return -1;
  endfunction

  function automatic int target_edges();
    int b;
    case (m_phase)
      1: b = FILL_T;
      2: b = WASH_T;
      3: b = RINSE_T;
      4: b = DRAIN_T;
      5: b = SPIN_T;
      default: b = 0;
    endcase
    return b * (m_load + 1) * TICK_DIV;
  endfunction

  function automatic logic [4:0] exp_flags();
    if (m_phase == 0 || m_elapsed < target_edges()) return 5'b00000;
    case (m_phase)
      1: return 5'b01000;
      2: return 5'b00001;
      3: return 5'b00100;
      4: return 5'b10000;
      5: return 5'b00010;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0; m_elapsed = 0; m_load = 0; m_agit = 0;
  endtask

  task automatic model_step();
    int d;
    if (!reset_n || clr) begin
      model_reset();
    end else if (!door_v) begin
      d = decode({water, agitator, motor, pump, speed}, m_agit);
      if (d >= 0) begin
        if (d != m_phase) begin
          if (m_phase == 2 || m_phase == 3) m_agit = 1;
          if (m_phase == 0 && d == 1) m_load = int'(load);
          m_phase   = d;
          m_elapsed = 0;
        end else if (m_elapsed < 100000) begin
          m_elapsed++;
        end
      end
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_eq(tag, {td, tf, tr, ts, tw}, exp_flags());
  endtask

  task automatic run(input logic [4:0] a, input int n, input string tag);
    {water, agitator, motor, pump, speed} = a;
    repeat (n) tick(tag);
  endtask

  task automatic pulse_clr(input string tag);
    clr = 1'b1;
    tick(tag);
    clr = 1'b0;
  endtask

  task automatic async_reset(input string tag);
    reset_n = 1'b0;
    model_reset();
    #1;
    check_eq(tag, {td, tf, tr, ts, tw}, 5'b00000);
    tick(tag);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [4:0] pat;
    int         sel;
    reset_n = 1'b0; clr = 1'b0; load = 2'd0; door_v = 1'b0;
    {water, agitator, motor, pump, speed} = A_IDLE;
    model_reset();
    #22;
    check_eq("reset_async", {td, tf, tr, ts, tw}, 5'b00000);
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick("reset_idle");

    // load=1 fill: target 6 units, flag 24 edges after the phase update
    load = 2'd1;
    run(A_FILL, 30, "s1_fill");
    run(A_IDLE, 3, "s1_idle");

    // full cycle at load 0
    load = 2'd0;
    run(A_FILL, 14, "s2_fill1");
    run(A_AGIT, 24, "s2_wash");
    run(A_DRAIN, 10, "s2_drain1");
    run(A_FILL, 14, "s2_fill2");
    run(A_AGIT1, 12, "s2_rinse");
    run(A_DRAIN, 10, "s2_drain2");
    run(A_SPIN, 15, "s2_spin");
    run(A_IDLE, 2, "s2_idle");

    // load change inside wash is ignored; next IDLE->FILL latches it
    pulse_clr("s3_clr");
    run(A_FILL, 14, "s3_fill");
    run(A_AGIT, 5, "s3_wash_a");
    load = 2'd3;
    run(A_AGIT, 20, "s3_wash_b");
    run(A_DRAIN, 3, "s3_drain");
    run(A_IDLE, 2, "s3_idle");
    run(A_FILL, 52, "s3_fill_l3");

    // async reset while tw is high, then wash restarts from scratch
    load = 2'd0;
    pulse_clr("s4_clr");
    run(A_FILL, 13, "s4_fill");
    run(A_AGIT, 22, "s4_wash");
    async_reset("s4_rst");
    run(A_AGIT, 25, "s4_wash_again");

    // illegal pattern freezes timing mid-fill
    pulse_clr("s5_clr0");
    run(A_FILL, 9, "s5_fill_a");
    run(A_ILL, 10, "s5_hold");
    run(A_FILL, 20, "s5_fill_b");
    pulse_clr("s5_clr");
    run(A_FILL, 3, "s5_after_clr");

`ifdef DOOR_PAUSE_EN
    pulse_clr("s6_clr");
    run(A_IDLE, 1, "s6_idle");
    run(A_FILL, 6, "s6_fill_a");
    door_v = 1'b1;
    run(A_FILL, 7, "s6_door");
    door_v = 1'b0;
    run(A_FILL, 10, "s6_fill_b");
`else
    pulse_clr("s6_clr");
    run(A_IDLE, 1, "s6_idle");
    run(A_FILL, 16, "s6_fill");
`endif

    // randomized actuator sequences
    for (int seg = 0; seg < 300; seg++) begin
      sel = $urandom_range(0, 11);
      case (sel)
        0, 1:    pat = A_FILL;
        2, 3:    pat = A_AGIT;
        4:       pat = A_AGIT1;
        5, 6:    pat = A_DRAIN;
        7, 8:    pat = A_SPIN;
        9, 10:   pat = A_IDLE;
        default: pat = 5'($urandom_range(0, 31));
      endcase
      if ($urandom_range(0, 3) == 0) load = 2'($urandom_range(0, 3));
`ifdef DOOR_PAUSE_EN
      door_v = ($urandom_range(0, 5) == 0);
`endif
      run(pat, $urandom_range(1, 30), "rand");
      if ($urandom_range(0, 24) == 0) pulse_clr("rand_clr");
      if ($urandom_range(0, 49) == 0) async_reset("rand_rst");
    end
    door_v = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
